// File: rtl/hex_page_seq.sv
// Page sequencer for the HEX display mux. A debounced push-button press and an
// optional periodic auto-advance step the page select through A -> B -> C -> A.
module hex_page_seq #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int AUTO_CYCLES     = 100_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_btn_n,
  input  logic       i_auto_en,
  input  logic       i_hold,
  output logic [1:0] o_sel,
  output logic       o_advance,
  output logic       o_btn_db
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int AW = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;

  localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW-1:0] ACNT_LAST = AW'(AUTO_CYCLES - 1);

  localparam logic [1:0] PG_A = 2'b00;
  localparam logic [1:0] PG_B = 2'b01;
  localparam logic [1:0] PG_C = 2'b10;

  logic          r_s1;
  logic          r_s2;
  logic          r_stable;
  logic          r_stable_d;
  logic [DW-1:0] r_dcnt;
  logic          r_press;
  logic [AW-1:0] r_acnt;
  logic          r_auto;
  logic [1:0]    r_sel;
  logic          r_advance;

  logic          w_press_det;
  logic          w_press_take;
  logic          w_auto_run;
  logic          w_acnt_wrap;
  logic          w_accept;
  logic [1:0]    w_sel_next;
  logic          w_adv_next;

  // Two-flop synchronizer; idle level is high because the button is active-low.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= i_btn_n;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stable   <= 1'b1;
      r_stable_d <= 1'b1;
      r_dcnt     <= '0;
      r_press    <= 1'b0;
    end else begin
      r_stable_d <= r_stable;
      r_press    <= w_press_det;
      if (r_s2 == r_stable) begin
        r_dcnt <= '0;
      end else if (r_dcnt == DCNT_LAST) begin
        r_stable <= r_s2;
        r_dcnt   <= '0;
      end else begin
        r_dcnt <= r_dcnt + DW'(1);
      end
    end
  end

  // Only the falling edge of the debounced level is a press; release is ignored.
  assign w_press_det  = r_stable_d & ~r_stable;
  assign w_press_take = w_press_det & ~i_hold;
  assign w_auto_run   = i_auto_en & ~i_hold;
  assign w_acnt_wrap  = (r_acnt == ACNT_LAST);

  // A press restarts the period and suppresses a coincident wrap, so a
  // press and an auto event landing together still move only one page.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acnt <= '0;
      r_auto <= 1'b0;
    end else if (!w_auto_run || w_press_take) begin
      r_acnt <= '0;
      r_auto <= 1'b0;
    end else if (w_acnt_wrap) begin
      r_acnt <= '0;
      r_auto <= 1'b1;
    end else begin
      r_acnt <= r_acnt + AW'(1);
      r_auto <= 1'b0;
    end
  end

  assign w_accept = (r_press | r_auto) & ~i_hold;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_sel_next = r_sel;
    w_adv_next = 1'b0;
    case (r_sel)
      PG_A: if (w_accept) begin
        w_sel_next = PG_B;
        w_adv_next = 1'b1;
      end
      PG_B: if (w_accept) begin
        w_sel_next = PG_C;
        w_adv_next = 1'b1;
      end
      PG_C: if (w_accept) begin
        w_sel_next = PG_A;
        w_adv_next = 1'b1;
      end
      default: w_sel_next = PG_A;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sel     <= PG_A;
      r_advance <= 1'b0;
    end else begin
      r_sel     <= w_sel_next;
      r_advance <= w_adv_next;
    end
  end

  assign o_sel     = r_sel;
  assign o_advance = r_advance;
  assign o_btn_db  = r_stable;

endmodule

// File: tb/tb_hex_page_seq.sv
// Directed bench for hex_page_seq with DEBOUNCE_CYCLES=4, AUTO_CYCLES=10.
// Tick t means "just after the t-th rising edge following the stimulus change".
module tb_hex_page_seq;

  logic       clk;
  logic       rst;
  logic       btn_n;
  logic       auto_en;
  logic       hold;
  logic [1:0] sel;
  logic       advance;
  logic       btn_db;

  int total;
  int bad;

  hex_page_seq #(
    .DEBOUNCE_CYCLES(4),
    .AUTO_CYCLES    (10)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_btn_n  (btn_n),
    .i_auto_en(auto_en),
    .i_hold   (hold),
    .o_sel    (sel),
    .o_advance(advance),
    .o_btn_db (btn_db)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    btn_n = 1'b0; auto_en = 1'b0; hold = 1'b0; rst = 1'b1;
    repeat (3) tick();
    total++; if (sel !== 2'b00) begin bad++; $display("FAIL reset_sel: got %b expected 00", sel); end
    total++; if (advance !== 1'b0) begin bad++; $display("FAIL reset_adv: got %b expected 0", advance); end
    total++; if (btn_db !== 1'b1) begin bad++; $display("FAIL reset_btn_db: got %b expected 1", btn_db); end
    rst = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      tick();
      if (t == 5) begin
        total++; if (btn_db !== 1'b1) begin bad++; $display("FAIL reset_db_early t=5: got %b expected 1", btn_db); end
      end
      if (t == 6) begin
        total++; if (btn_db !== 1'b0) begin bad++; $display("FAIL reset_db_fall t=6: got %b expected 0", btn_db); end
      end
    end
    // Reset again while the press event is pending: it must be discarded.
    rst = 1'b1; btn_n = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (6) tick();
    total++; if (sel !== 2'b00) begin bad++; $display("FAIL reset_pending_sel: got %b expected 00", sel); end
  endtask

  task automatic test_clean_press();
    int n_adv;
    int first_adv;
    logic [1:0] exp_sel;
    for (int i = 0; i < 3; i++) begin
      exp_sel = 2'((i + 1) % 3);
      btn_n = 1'b0; n_adv = 0; first_adv = 0;
      for (int t = 1; t <= 20; t++) begin
        tick();
        if (advance) begin n_adv++; if (first_adv == 0) first_adv = t; end
      end
      total++; if (n_adv !== 1) begin bad++; $display("FAIL press%0d_count: got %0d expected 1", i, n_adv); end
      total++; if (first_adv !== 8) begin bad++; $display("FAIL press%0d_timing: got tick %0d expected 8", i, first_adv); end
      total++; if (sel !== exp_sel) begin bad++; $display("FAIL press%0d_sel: got %b expected %b", i, sel, exp_sel); end
      btn_n = 1'b1; n_adv = 0;
      for (int t = 1; t <= 20; t++) begin
        tick();
        if (advance) n_adv++;
      end
      total++; if (n_adv !== 0) begin bad++; $display("FAIL release%0d_adv: got %0d expected 0", i, n_adv); end
      total++; if (btn_db !== 1'b1) begin bad++; $display("FAIL release%0d_db: got %b expected 1", i, btn_db); end
    end
  endtask

  task automatic test_bounce();
    int n_adv;
    int first_adv;
    int first_low;
    int n_low;
    n_adv = 0; first_adv = 0; first_low = 0;
    // Low 3, high 1, then low for good: debounce restarts at tick 5.
    for (int t = 1; t <= 30; t++) begin
      btn_n = (t == 4);
      tick();
      if (!btn_db && first_low == 0) first_low = t;
      if (advance) begin n_adv++; if (first_adv == 0) first_adv = t; end
    end
    total++; if (first_low !== 10) begin bad++; $display("FAIL bounce_db_fall: got tick %0d expected 10", first_low); end
    total++; if (first_adv !== 12) begin bad++; $display("FAIL bounce_adv_timing: got tick %0d expected 12", first_adv); end
    total++; if (n_adv !== 1) begin bad++; $display("FAIL bounce_adv_count: got %0d expected 1", n_adv); end
    total++; if (sel !== 2'b01) begin bad++; $display("FAIL bounce_sel: got %b expected 01", sel); end
    btn_n = 1'b1;
    repeat (20) tick();
    n_adv = 0; n_low = 0;
    for (int t = 1; t <= 20; t++) begin
      btn_n = !(t <= 3 || t == 7 || t == 9 || t == 10);
      tick();
      if (!btn_db) n_low++;
      if (advance) n_adv++;
    end
    total++; if (n_low !== 0) begin bad++; $display("FAIL glitch_db: got %0d low ticks expected 0", n_low); end
    total++; if (n_adv !== 0) begin bad++; $display("FAIL glitch_adv: got %0d expected 0", n_adv); end
  endtask

  task automatic test_auto();
    int n_adv;
    int first_adv;
    btn_n = 1'b1; hold = 1'b0; auto_en = 1'b1; rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0; n_adv = 0;
    for (int t = 1; t <= 31; t++) begin
      tick();
      if (advance) n_adv++;
      if (t == 11) begin
        total++; if (advance !== 1'b1 || sel !== 2'b01) begin bad++; $display("FAIL auto_t11: got adv=%b sel=%b expected adv=1 sel=01", advance, sel); end
      end
      if (t == 12) begin
        total++; if (advance !== 1'b0) begin bad++; $display("FAIL auto_t12_pulse: got %b expected 0", advance); end
      end
      if (t == 21) begin
        total++; if (advance !== 1'b1 || sel !== 2'b10) begin bad++; $display("FAIL auto_t21: got adv=%b sel=%b expected adv=1 sel=10", advance, sel); end
      end
      if (t == 31) begin
        total++; if (advance !== 1'b1 || sel !== 2'b00) begin bad++; $display("FAIL auto_t31: got adv=%b sel=%b expected adv=1 sel=00", advance, sel); end
      end
    end
    total++; if (n_adv !== 3) begin bad++; $display("FAIL auto_count: got %0d expected 3", n_adv); end
    repeat (5) tick();
    auto_en = 1'b0; n_adv = 0;
    repeat (5) begin tick(); if (advance) n_adv++; end
    auto_en = 1'b1; first_adv = 0;
    for (int t = 1; t <= 14; t++) begin
      tick();
      if (advance) begin n_adv++; if (first_adv == 0) first_adv = t; end
    end
    total++; if (first_adv !== 11) begin bad++; $display("FAIL auto_rearm_timing: got tick %0d expected 11", first_adv); end
    total++; if (n_adv !== 1) begin bad++; $display("FAIL auto_rearm_count: got %0d expected 1", n_adv); end
    total++; if (sel !== 2'b01) begin bad++; $display("FAIL auto_rearm_sel: got %b expected 01", sel); end
  endtask

  task automatic test_collision_hold();
    int n_adv;
    int n_low;
    // Press detected on the same edge the auto counter sits at 9.
    btn_n = 1'b1; hold = 1'b0; auto_en = 1'b1; rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0; n_adv = 0;
    for (int t = 1; t <= 22; t++) begin
      if (t == 4) btn_n = 1'b0;
      tick();
      if (advance) n_adv++;
      if (t == 11) begin
        total++; if (advance !== 1'b1 || sel !== 2'b01) begin bad++; $display("FAIL collide_t11: got adv=%b sel=%b expected adv=1 sel=01", advance, sel); end
      end
      if (t == 21) begin
        total++; if (advance !== 1'b1 || sel !== 2'b10) begin bad++; $display("FAIL collide_t21: got adv=%b sel=%b expected adv=1 sel=10", advance, sel); end
      end
    end
    total++; if (n_adv !== 2) begin bad++; $display("FAIL collide_count: got %0d expected 2", n_adv); end

    // Press mid-period restarts the auto period.
    btn_n = 1'b1; rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0; btn_n = 1'b0; n_adv = 0;
    for (int t = 1; t <= 19; t++) begin
      tick();
      if (advance) n_adv++;
      if (t == 8) begin
        total++; if (advance !== 1'b1 || sel !== 2'b01) begin bad++; $display("FAIL restart_t8: got adv=%b sel=%b expected adv=1 sel=01", advance, sel); end
      end
      if (t == 18) begin
        total++; if (advance !== 1'b1 || sel !== 2'b10) begin bad++; $display("FAIL restart_t18: got adv=%b sel=%b expected adv=1 sel=10", advance, sel); end
      end
    end
    total++; if (n_adv !== 2) begin bad++; $display("FAIL restart_count: got %0d expected 2", n_adv); end

    btn_n = 1'b1; rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0; hold = 1'b1; n_adv = 0; n_low = 0;
    for (int t = 1; t <= 35; t++) begin
      btn_n = (t > 15);
      tick();
      if (advance) n_adv++;
      if (!btn_db) n_low++;
    end
    total++; if (n_adv !== 0) begin bad++; $display("FAIL hold_adv: got %0d expected 0", n_adv); end
    total++; if (sel !== 2'b00) begin bad++; $display("FAIL hold_sel: got %b expected 00", sel); end
    total++; if ((n_low != 0) !== 1'b1) begin bad++; $display("FAIL hold_db_tracks: got %0d low ticks expected nonzero", n_low); end
    hold = 1'b0; auto_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int first_low;
    int first_adv;
    btn_n = 1'b1; hold = 1'b0; auto_en = 1'b0; rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) begin
      btn_n = 1'b0; repeat (10) tick();
      btn_n = 1'b1; repeat (10) tick();
    end
    total++; if (sel !== 2'b10) begin bad++; $display("FAIL mid_setup_sel: got %b expected 10", sel); end
    btn_n = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    total++; if (sel !== 2'b00 || advance !== 1'b0 || btn_db !== 1'b1)
      begin bad++; $display("FAIL mid_reset: got sel=%b adv=%b db=%b expected sel=00 adv=0 db=1", sel, advance, btn_db); end
    rst = 1'b0; first_low = 0; first_adv = 0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (!btn_db && first_low == 0) first_low = t;
      if (advance && first_adv == 0) first_adv = t;
    end
    total++; if (first_low !== 6) begin bad++; $display("FAIL mid_db_fall: got tick %0d expected 6", first_low); end
    total++; if (first_adv !== 8) begin bad++; $display("FAIL mid_adv_timing: got tick %0d expected 8", first_adv); end
    total++; if (sel !== 2'b01) begin bad++; $display("FAIL mid_sel: got %b expected 01", sel); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; btn_n = 1'b1; auto_en = 1'b0; hold = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto();
    test_collision_hold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
